// File: rtl/nibble_demux4.sv
// 1:4 nibble demultiplexing capture bank: steers handshaked nibbles into four
// held lanes (addressed or round-robin) and presents the completed frame downstream.
module nibble_demux4 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] din,
    input  logic         mode,
    input  logic [1:0]   ctrl,
    output logic [W-1:0] A,
    output logic [W-1:0] B,
    output logic [W-1:0] C,
    output logic [W-1:0] D,
    output logic [3:0]   lane_mask,
    output logic [1:0]   ptr,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0] state;
    logic       accept;
    logic [1:0] lane;
    logic [3:0] lane_sel;
    logic [3:0] next_mask;

    assign in_ready  = (state == FILL);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;
    assign lane      = mode ? ptr : ctrl;
    assign lane_sel  = 4'b0001 << lane;
    assign next_mask = lane_mask | lane_sel;

    // NOTE: all state updates use <= so every branch sees the pre-edge values
    // of lane_mask and ptr, matching the combinational next_mask above.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            A         <= '0;
            B         <= '0;
            C         <= '0;
            D         <= '0;
            lane_mask <= 4'b0000;
            ptr       <= 2'd0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        if (lane_sel[0]) A <= din;
                        if (lane_sel[1]) B <= din;
                        if (lane_sel[2]) C <= din;
                        if (lane_sel[3]) D <= din;
                        lane_mask <= next_mask;
                        if (mode) ptr <= ptr + 2'd1;
                        if (next_mask == 4'b1111) state <= HOLD;
                    end
                end
                HOLD: begin
                    // Lanes keep the last frame after consume; only bookkeeping restarts.
                    if (out_ready) begin
                        state     <= FILL;
                        lane_mask <= 4'b0000;
                        ptr       <= 2'd0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_demux4.sv
// Directed self-checking bench for nibble_demux4: one task per scenario,
// inline comparisons against hand-computed expectations.
module tb_nibble_demux4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] din;
    logic       mode;
    logic [1:0] ctrl;
    logic [3:0] A, B, C, D;
    logic [3:0] lane_mask;
    logic [1:0] ptr;
    logic       out_valid;
    logic       out_ready;

    int pass_cnt = 0;
    int total_cnt = 0;

    nibble_demux4 #(.W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .mode      (mode),
        .ctrl      (ctrl),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .lane_mask (lane_mask),
        .ptr       (ptr),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled off the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; din = 4'h0; mode = 1'b0; ctrl = 2'd0; out_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        total_cnt++;
        if ({A, B, C, D} !== 16'h0000) $display("FAIL reset_lanes got=%h exp=0000", {A, B, C, D});
        else pass_cnt++;
        total_cnt++;
        if ({lane_mask, ptr, out_valid, in_ready} !== {4'b0000, 2'd0, 1'b0, 1'b1})
            $display("FAIL reset_ctl mask=%b ptr=%0d ov=%b ir=%b exp mask=0000 ptr=0 ov=0 ir=1",
                     lane_mask, ptr, out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_sequential();
        mode = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            din = 4'(i);
            cycle();
            if (i == 3) begin
                total_cnt++;
                if (out_valid !== 1'b0 || lane_mask !== 4'b0111)
                    $display("FAIL seq_3rd ov=%b mask=%b exp ov=0 mask=0111", out_valid, lane_mask);
                else pass_cnt++;
            end
        end
        in_valid = 1'b0;
        total_cnt++;
        if ({A, B, C, D} !== 16'h1234) $display("FAIL seq_lanes got=%h exp=1234", {A, B, C, D});
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || lane_mask !== 4'b1111)
            $display("FAIL seq_hold ov=%b ir=%b mask=%b exp ov=1 ir=0 mask=1111",
                     out_valid, in_ready, lane_mask);
        else pass_cnt++;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || lane_mask !== 4'b0000 || ptr !== 2'd0)
            $display("FAIL seq_consume ov=%b mask=%b ptr=%0d exp ov=0 mask=0000 ptr=0",
                     out_valid, lane_mask, ptr);
        else pass_cnt++;
    endtask

    task automatic test_addressed();
        logic [1:0] ctrl_v [5] = '{2'd3, 2'd0, 2'd3, 2'd1, 2'd2};
        logic [3:0] din_v  [5] = '{4'h9, 4'h5, 4'h7, 4'h2, 4'h8};
        mode = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ctrl = ctrl_v[i];
            din  = din_v[i];
            cycle();
            if (i == 2) begin
                total_cnt++;
                if (D !== 4'h7 || lane_mask !== 4'b1001 || ptr !== 2'd0)
                    $display("FAIL addr_overwrite D=%h mask=%b ptr=%0d exp D=7 mask=1001 ptr=0",
                             D, lane_mask, ptr);
                else pass_cnt++;
            end
            if (i == 3) begin
                total_cnt++;
                if (out_valid !== 1'b0 || lane_mask !== 4'b1011)
                    $display("FAIL addr_4th ov=%b mask=%b exp ov=0 mask=1011", out_valid, lane_mask);
                else pass_cnt++;
            end
        end
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || {A, B, C, D} !== 16'h5287)
            $display("FAIL addr_frame ov=%b lanes=%h exp ov=1 lanes=5287", out_valid, {A, B, C, D});
        else pass_cnt++;
    endtask

    task automatic test_hold();
        mode = 1'b1; in_valid = 1'b1; din = 4'hF;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total_cnt++;
            if ({A, B, C, D} !== 16'h5287 || in_ready !== 1'b0 || out_valid !== 1'b1 ||
                lane_mask !== 4'b1111 || ptr !== 2'd0)
                $display("FAIL hold_ignore%0d lanes=%h ir=%b ov=%b mask=%b ptr=%0d exp 5287 0 1 1111 0",
                         i, {A, B, C, D}, in_ready, out_valid, lane_mask, ptr);
            else pass_cnt++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || lane_mask !== 4'b0000 || ptr !== 2'd0 || in_ready !== 1'b1)
            $display("FAIL hold_consume ov=%b mask=%b ptr=%0d ir=%b exp 0 0000 0 1",
                     out_valid, lane_mask, ptr, in_ready);
        else pass_cnt++;
        total_cnt++;
        if ({A, B, C, D} !== 16'h5287) $display("FAIL hold_retain lanes=%h exp=5287", {A, B, C, D});
        else pass_cnt++;
    endtask

    task automatic test_mixed();
        mode = 1'b1; in_valid = 1'b1; din = 4'h6;
        cycle();
        total_cnt++;
        if (A !== 4'h6 || ptr !== 2'd1 || lane_mask !== 4'b0001)
            $display("FAIL mix_seq A=%h ptr=%0d mask=%b exp 6 1 0001", A, ptr, lane_mask);
        else pass_cnt++;
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        total_cnt++;
        if (ptr !== 2'd1 || lane_mask !== 4'b0001 || out_valid !== 1'b0)
            $display("FAIL mix_ready_in_fill ptr=%0d mask=%b ov=%b exp 1 0001 0", ptr, lane_mask, out_valid);
        else pass_cnt++;
        mode = 1'b0; ctrl = 2'd0; din = 4'hE; in_valid = 1'b1;
        cycle();
        total_cnt++;
        if (A !== 4'hE || ptr !== 2'd1 || lane_mask !== 4'b0001)
            $display("FAIL mix_addr A=%h ptr=%0d mask=%b exp E 1 0001", A, ptr, lane_mask);
        else pass_cnt++;
        mode = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            din = 4'(i);
            cycle();
        end
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || {A, B, C, D} !== 16'hE123)
            $display("FAIL mix_frame ov=%b lanes=%h exp ov=1 lanes=E123", out_valid, {A, B, C, D});
        else pass_cnt++;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midframe();
        mode = 1'b1; in_valid = 1'b1;
        din = 4'hA; cycle();
        din = 4'hB; cycle();
        // Reset asserted together with a valid nibble: reset must win.
        din = 4'h9; rst = 1'b1;
        cycle();
        rst = 1'b0; in_valid = 1'b0;
        total_cnt++;
        if ({A, B, C, D} !== 16'h0000 || lane_mask !== 4'b0000 || ptr !== 2'd0 || out_valid !== 1'b0)
            $display("FAIL mid_reset lanes=%h mask=%b ptr=%0d ov=%b exp 0000 0000 0 0",
                     {A, B, C, D}, lane_mask, ptr, out_valid);
        else pass_cnt++;
        in_valid = 1'b1; din = 4'hC;
        cycle();
        in_valid = 1'b0;
        total_cnt++;
        if ({A, B} !== 8'hC0 || ptr !== 2'd1 || lane_mask !== 4'b0001)
            $display("FAIL mid_after A=%h B=%h ptr=%0d mask=%b exp C 0 1 0001", A, B, ptr, lane_mask);
        else pass_cnt++;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int frames = 0;
        int rise_cyc [2] = '{0, 0};
        logic [15:0] frame_v [2] = '{16'h0, 16'h0};
        mode = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            in_valid = in_ready && (n < 8);
            din = 4'(n);
            cycle();
            if (in_valid) n++;
            if (out_valid === 1'b1 && frames < 2) begin
                rise_cyc[frames] = c;
                frame_v[frames] = {A, B, C, D};
                frames++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        total_cnt++;
        if (frames !== 2) $display("FAIL stream_count got=%0d exp=2", frames);
        else pass_cnt++;
        total_cnt++;
        if (frame_v[0] !== 16'h0123 || frame_v[1] !== 16'h4567)
            $display("FAIL stream_frames got=%h,%h exp=0123,4567", frame_v[0], frame_v[1]);
        else pass_cnt++;
        total_cnt++;
        if (rise_cyc[0] !== 4 || rise_cyc[1] - rise_cyc[0] !== 5)
            $display("FAIL stream_spacing first=%0d gap=%0d exp first=4 gap=5",
                     rise_cyc[0], rise_cyc[1] - rise_cyc[0]);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_addressed();
        test_hold();
        test_mixed();
        test_reset_midframe();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
